// File: rtl/md_pkg.sv
// Shared definitions for the RV32M divide/remainder unit: operation
// encodings, FSM state type and the iteration counter width.
package md_pkg;

  localparam int MD_DATA_WIDTH = 32;

  // MDOp encodings as presented on the execute-stage operand bus
  localparam logic [1:0] MD_DIV  = 2'b00;
  localparam logic [1:0] MD_DIVU = 2'b01;
  localparam logic [1:0] MD_REM  = 2'b10;
  localparam logic [1:0] MD_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bits needed to count 0..w-1 iterations
  function automatic int md_cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int MD_CNT_W = md_cnt_width(MD_DATA_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic                  dvd_msb,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic                  q_bit
);

  // The shifted remainder can exceed DATA_WIDTH bits when the divisor is
  // large, so the compare and subtract are done one bit wider.
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] divisor_ext;

  assign shifted     = {rem, dvd_msb};
  assign divisor_ext = {1'b0, divisor};
  assign q_bit       = (shifted >= divisor_ext);
  assign rem_next    = q_bit ? DATA_WIDTH'(shifted - divisor_ext)
                             : shifted[DATA_WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU). Works on
// operand magnitudes with one restoring step per cycle, fixes signs on the
// way out, and resolves divide-by-zero and signed overflow without iterating.
module div_unit
  import md_pkg::*;
#(
  parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [1:0]            MDOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int CNT_W = md_cnt_width(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  // Dividend shifts out of the top while quotient bits shift into the bottom
  logic [DATA_WIDTH-1:0] dq_q;
  logic [DATA_WIDTH-1:0] dsr_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic                  is_rem_q;
  logic                  neg_quo_q;
  logic                  neg_rem_q;
  logic [DATA_WIDTH-1:0] result_q;

  // Decode of the incoming request
  logic                  accept;
  logic                  in_signed;
  logic                  in_rem;
  logic                  div_zero;
  logic                  overflow;
  logic                  special;
  logic [DATA_WIDTH-1:0] special_result;
  logic [DATA_WIDTH-1:0] abs_a;
  logic [DATA_WIDTH-1:0] abs_b;

  // Iteration datapath
  logic [DATA_WIDTH-1:0] step_rem;
  logic                  step_q;
  logic                  last_iter;
  logic [DATA_WIDTH-1:0] quo_final;
  logic [DATA_WIDTH-1:0] rem_final;
  logic [DATA_WIDTH-1:0] calc_result;

  assign accept    = (state_q == S_IDLE) && Start && !Flush;
  assign in_signed = (MDOp == MD_DIV) || (MDOp == MD_REM);
  assign in_rem    = (MDOp == MD_REM) || (MDOp == MD_REMU);
  assign div_zero  = (SrcB == '0);
  assign overflow  = in_signed && (SrcA == MIN_NEG) && (SrcB == ALL_ONES);
  assign special   = div_zero || overflow;

  // Negating MIN_NEG wraps back to itself, which is its correct unsigned magnitude
  assign abs_a = (in_signed && SrcA[DATA_WIDTH-1]) ? -SrcA : SrcA;
  assign abs_b = (in_signed && SrcB[DATA_WIDTH-1]) ? -SrcB : SrcB;

  // Architected results for the cases that bypass iteration
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    special_result = '0;
    if (div_zero) begin
      special_result = in_rem ? SrcA : ALL_ONES;
    end else if (overflow) begin
      special_result = in_rem ? '0 : MIN_NEG;
    end
  end

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .rem     (rem_q),
    .dvd_msb (dq_q[DATA_WIDTH-1]),
    .divisor (dsr_q),
    .rem_next(step_rem),
    .q_bit   (step_q)
  );

  assign last_iter   = (cnt_q == CNT_LAST);
  assign quo_final   = {dq_q[DATA_WIDTH-2:0], step_q};
  assign rem_final   = step_rem;
  assign calc_result = is_rem_q ? (neg_rem_q ? -rem_final : rem_final)
                                : (neg_quo_q ? -quo_final : quo_final);

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Flush overrides everything
  always_comb begin
    state_d = state_q;
    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (Start) state_d = special ? S_DONE : S_CALC;
        S_CALC:  if (last_iter) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Status outputs decoded from state
  always_comb begin
    Busy = (state_q == S_CALC) || (state_q == S_DONE);
    Done = (state_q == S_DONE);
  end

  assign Result = result_q;

  // Operand latch, iteration registers and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dq_q      <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      dq_q      <= abs_a;
      dsr_q     <= abs_b;
      rem_q     <= '0;
      is_rem_q  <= in_rem;
      neg_quo_q <= in_signed && (SrcA[DATA_WIDTH-1] ^ SrcB[DATA_WIDTH-1]);
      neg_rem_q <= in_signed && SrcA[DATA_WIDTH-1];
      if (special) begin
        result_q <= special_result;
      end
    end else if ((state_q == S_CALC) && !Flush) begin
      cnt_q <= cnt_q + CNT_W'(1);
      dq_q  <= quo_final;
      rem_q <= step_rem;
      if (last_iter) begin
        result_q <= calc_result;
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a reference model fills a scoreboard
// queue at Start, and a monitor pops and compares on every Done pulse.
module tb_div_unit;
  import md_pkg::*;

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  MDOp = 2'b00;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        Flush = 1'b0;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_exp = '0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .MDOp  (MDOp),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .Flush (Flush),
    .Busy  (Busy),
    .Done  (Done),
    .Result(Result)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M-extension semantics using simulator arithmetic
  function automatic logic [31:0] ref_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == MINV) && (b == ONES);
    case (op)
      MD_DIV:  ref_md = (b == 0) ? ONES : (ovf ? MINV : 32'(sa / sb));
      MD_DIVU: ref_md = (b == 0) ? ONES : a / b;
      MD_REM:  ref_md = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: ref_md = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == MD_DIV) || (op == MD_REM);
    return ((b == 0) || (sgn && a == MINV && b == ONES)) ? 1 : 33;
  endfunction

  // Scoreboard monitor: every Done must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && Done === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: Result=%h with no request outstanding", Result);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        if (Result !== e) begin
          errors++;
          $display("FAIL scoreboard_result: got %h expected %h", Result, e);
        end
      end
    end
  end

  // Issue one request and follow it to Done; optionally pulse a second Start mid-op
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj, output int lat, output logic [31:0] res, output int busy_bad);
    logic [31:0] e;
    e = ref_md(op, a, b);
    @(posedge clk); #1;
    Start = 1'b1; MDOp = op; SrcA = a; SrcB = b;
    sb_q.push_back(e);
    last_exp = e;
    @(posedge clk); #1;
    Start = 1'b0;
    lat = -1; res = '0; busy_bad = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc == inj) begin
        Start = 1'b1; MDOp = MD_DIVU; SrcA = 32'd200; SrcB = 32'd3;
      end
      @(negedge clk);
      if (Busy !== 1'b1) busy_bad++;
      if (Done === 1'b1) begin
        lat = cyc;
        res = Result;
        break;
      end
      @(posedge clk); #1;
      Start = 1'b0;
    end
    Start = 1'b0;
  endtask

  // Count Done pulses over a window where none are allowed
  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (Done === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: Busy=%b Done=%b Result=%h expected 0 0 00000000", Busy, Done, Result);
    end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    int lat, bb;
    logic [31:0] res;
    do_op(MD_DIVU, 32'd100, 32'd7, 0, lat, res, bb);
    checks++;
    if (lat !== 33 || bb !== 0 || res !== 32'd14) begin
      errors++;
      $display("FAIL divu_100_7: lat=%0d busy_gaps=%0d res=%h expected 33 0 0000000e", lat, bb, res);
    end
    do_op(MD_REMU, 32'd100, 32'd7, 0, lat, res, bb);
    checks++;
    if (lat !== 33 || bb !== 0 || res !== 32'd2) begin
      errors++;
      $display("FAIL remu_100_7: lat=%0d busy_gaps=%0d res=%h expected 33 0 00000002", lat, bb, res);
    end
  endtask

  task automatic test_signed;
    int lat, bb;
    logic [31:0] res;
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0, lat, res, bb);
    checks++;
    if (lat !== 33 || res !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_m7_2: lat=%0d res=%h expected 33 fffffffd", lat, res);
    end
    do_op(MD_REM, 32'hFFFF_FFF9, 32'd2, 0, lat, res, bb);
    checks++;
    if (lat !== 33 || res !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL rem_m7_2: lat=%0d res=%h expected 33 ffffffff", lat, res);
    end
    do_op(MD_REM, 32'd7, 32'hFFFF_FFFE, 0, lat, res, bb);
    checks++;
    if (lat !== 33 || res !== 32'd1) begin
      errors++;
      $display("FAIL rem_7_m2: lat=%0d res=%h expected 33 00000001", lat, res);
    end
  endtask

  task automatic test_div_zero;
    int lat, bb;
    logic [31:0] res;
    do_op(MD_DIVU, 32'd5, 32'd0, 0, lat, res, bb);
    checks++;
    if (lat !== 1 || res !== ONES) begin
      errors++;
      $display("FAIL divu_by_zero: lat=%0d res=%h expected 1 ffffffff", lat, res);
    end
    do_op(MD_REM, 32'd5, 32'd0, 0, lat, res, bb);
    checks++;
    if (lat !== 1 || res !== 32'd5) begin
      errors++;
      $display("FAIL rem_by_zero: lat=%0d res=%h expected 1 00000005", lat, res);
    end
    do_op(MD_DIV, ONES, 32'd0, 0, lat, res, bb);
    checks++;
    if (lat !== 1 || res !== ONES) begin
      errors++;
      $display("FAIL div_m1_by_zero: lat=%0d res=%h expected 1 ffffffff", lat, res);
    end
  endtask

  task automatic test_overflow;
    int lat, bb;
    logic [31:0] res;
    do_op(MD_DIV, MINV, ONES, 0, lat, res, bb);
    checks++;
    if (lat !== 1 || res !== MINV) begin
      errors++;
      $display("FAIL div_overflow: lat=%0d res=%h expected 1 80000000", lat, res);
    end
    do_op(MD_REM, MINV, ONES, 0, lat, res, bb);
    checks++;
    if (lat !== 1 || res !== 32'h0) begin
      errors++;
      $display("FAIL rem_overflow: lat=%0d res=%h expected 1 00000000", lat, res);
    end
  endtask

  task automatic test_boundaries;
    int lat, bb;
    logic [31:0] res;
    do_op(MD_DIV, 32'd0, 32'd9, 0, lat, res, bb);
    checks++;
    if (lat !== 33 || res !== 32'h0) begin
      errors++;
      $display("FAIL zero_dividend: lat=%0d res=%h expected 33 00000000", lat, res);
    end
    do_op(MD_DIVU, 32'hDEAD_BEEF, 32'd1, 0, lat, res, bb);
    checks++;
    if (lat !== 33 || res !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL divisor_one: lat=%0d res=%h expected 33 deadbeef", lat, res);
    end
  endtask

  task automatic test_flush;
    int cnt, lat, bb;
    logic [31:0] prev, res;
    prev = last_exp;
    @(posedge clk); #1;
    Start = 1'b1; MDOp = MD_DIVU; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (9) @(posedge clk);
    #1 Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: Busy=%b expected 0", Busy);
    end
    count_done(50, cnt);
    checks++;
    if (cnt !== 0 || Result !== prev) begin
      errors++;
      $display("FAIL flush_no_done: dones=%0d Result=%h expected 0 %h", cnt, Result, prev);
    end
    do_op(MD_DIVU, 32'd1000, 32'd3, 0, lat, res, bb);
    checks++;
    if (lat !== 33 || res !== 32'd333) begin
      errors++;
      $display("FAIL after_flush: lat=%0d res=%h expected 33 0000014d", lat, res);
    end
  endtask

  task automatic test_start_flush;
    int cnt, busy_hi;
    @(posedge clk); #1;
    Start = 1'b1; Flush = 1'b1; MDOp = MD_DIVU; SrcA = 32'd50; SrcB = 32'd5;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    busy_hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (Busy !== 1'b0) busy_hi++;
    end
    count_done(40, cnt);
    checks++;
    if (busy_hi !== 0 || cnt !== 0) begin
      errors++;
      $display("FAIL start_flush_same_cycle: busy_cycles=%0d dones=%0d expected 0 0", busy_hi, cnt);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bb;
    logic [31:0] res;
    do_op(MD_DIVU, 32'd100, 32'd7, 5, lat, res, bb);
    checks++;
    if (lat !== 33 || bb !== 0 || res !== 32'd14) begin
      errors++;
      $display("FAIL start_while_busy: lat=%0d busy_gaps=%0d res=%h expected 33 0 0000000e", lat, bb, res);
    end
  endtask

  task automatic test_reset_mid;
    int cnt;
    @(posedge clk); #1;
    Start = 1'b1; MDOp = MD_DIVU; SrcA = 32'd777; SrcB = 32'd5;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_op: Busy=%b Done=%b Result=%h expected 0 0 00000000", Busy, Done, Result);
    end
    count_done(45, cnt);
    checks++;
    if (cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_done: dones=%0d expected 0", cnt);
    end
    last_exp = '0;
  endtask

  task automatic test_back_to_back;
    int lat, bb, bad;
    logic [31:0] res, a, b;
    logic [1:0] op;
    logic [31:0] corners[5];
    corners = '{32'h0, 32'h1, ONES, MINV, 32'h7};
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 50)) : $urandom;
      do_op(op, a, b, 0, lat, res, bb);
      checks++;
      if (lat !== exp_lat(op, a, b) || bb !== 0) begin
        errors++;
        bad++;
        $display("FAIL random_latency: op=%0d a=%h b=%h lat=%0d busy_gaps=%0d expected %0d 0", op, a, b, lat, bb, exp_lat(op, a, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_boundaries();
    test_flush();
    test_start_flush();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
